// File: rtl/cc_speed_pkg.sv
// Shared speed-counter definitions: FSM state encoding, level width and level-to-limit mapping.
// Reused by the speed comparator testbench.
package cc_speed_pkg;

  localparam logic [2:0] STATE_INIT       = 3'd0;
  localparam logic [2:0] STATE_LD_SETUP   = 3'd1;
  localparam logic [2:0] STATE_LD_STROBE  = 3'd2;
  localparam logic [2:0] STATE_LD_RELEASE = 3'd3;
  localparam logic [2:0] STATE_RUN        = 3'd4;

  typedef enum logic [2:0] {
    INIT       = STATE_INIT,
    LD_SETUP   = STATE_LD_SETUP,
    LD_STROBE  = STATE_LD_STROBE,
    LD_RELEASE = STATE_LD_RELEASE,
    RUN        = STATE_RUN
  } speedState_t;

  // A single level still needs a one-bit level bus.
  function automatic int levelWidth(input int levels);
    if (levels <= 2) begin
      return 1;
    end else begin
      return $clog2(levels);
    end
  endfunction

  // Each level up halves the period; callers truncate to their data width.
  function automatic logic [63:0] levelToLimit(input logic [63:0] base, input logic [31:0] level);
    return base >> level;
  endfunction

endpackage

// File: rtl/cc_speedcounter_edgedetect.sv
// Button conditioner: 2-flop synchronizer plus a one-cycle request pulse on each falling edge.
module cc_speedcounter_edgedetect (
  input  logic clk,
  input  logic rst_n,
  input  logic buttonLow,
  output logic request
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronize the raw button and keep the previous synchronized level; idle is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= buttonLow;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign request = prev_r & ~sync2_r;

endmodule

// File: rtl/cc_speedcounter.sv
// Speed-level tick generator that loads and drives the external speed comparator.
// Define CC_SPEEDCOUNTER_WATCHDOG_EN to recover from a comparator holding a stale limit.
module cc_speedcounter
  import cc_speed_pkg::*;
#(
  parameter int SPEEDCOUNTER_DATAWIDTH = 28,
  parameter int SPEEDCOUNTER_LEVELS = 4,
  parameter logic [SPEEDCOUNTER_DATAWIDTH-1:0] SPEEDCOUNTER_BASELIMIT = 28'd50_000_000
) (
  input  logic CC_SPEEDCOUNTER_CLOCK_50,
  input  logic CC_SPEEDCOUNTER_RESET_InLow,
  input  logic CC_SPEEDCOUNTER_enable_InHigh,
  input  logic CC_SPEEDCOUNTER_speedUp_InLow,
  input  logic CC_SPEEDCOUNTER_speedDown_InLow,
  input  logic CC_SPEEDCOUNTER_compare_InLow,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_limit_OutBUS,
  output logic CC_SPEEDCOUNTER_loadSignal_OutLow,
  output logic CC_SPEEDCOUNTER_tick_OutHigh,
  output logic [levelWidth(SPEEDCOUNTER_LEVELS)-1:0] CC_SPEEDCOUNTER_level_OutBUS
);

  localparam int LW = levelWidth(SPEEDCOUNTER_LEVELS);
  localparam logic [LW-1:0] MAX_LEVEL = LW'(SPEEDCOUNTER_LEVELS - 1);

  speedState_t state_r;
  logic [SPEEDCOUNTER_DATAWIDTH-1:0] count_r;
  logic [SPEEDCOUNTER_DATAWIDTH-1:0] limit_r;
  logic loadN_r;
  logic tick_r;
  logic [LW-1:0] level_r;

  logic upReq_s;
  logic downReq_s;
  logic levelChange_s;
  logic [LW-1:0] nextLevel_s;
  logic [SPEEDCOUNTER_DATAWIDTH-1:0] nextLimit_s;

  cc_speedcounter_edgedetect upDetect (
    .clk       (CC_SPEEDCOUNTER_CLOCK_50),
    .rst_n     (CC_SPEEDCOUNTER_RESET_InLow),
    .buttonLow (CC_SPEEDCOUNTER_speedUp_InLow),
    .request   (upReq_s)
  );

  cc_speedcounter_edgedetect downDetect (
    .clk       (CC_SPEEDCOUNTER_CLOCK_50),
    .rst_n     (CC_SPEEDCOUNTER_RESET_InLow),
    .buttonLow (CC_SPEEDCOUNTER_speedDown_InLow),
    .request   (downReq_s)
  );

  // Saturating level update; simultaneous up and down cancel each other.
  always_comb begin
    levelChange_s = 1'b0;
    nextLevel_s   = level_r;
    if (upReq_s && !downReq_s && (level_r != MAX_LEVEL)) begin
      levelChange_s = 1'b1;
      nextLevel_s   = level_r + LW'(1);
    end else if (downReq_s && !upReq_s && (level_r != LW'(0))) begin
      levelChange_s = 1'b1;
      nextLevel_s   = level_r - LW'(1);
    end else begin
      levelChange_s = 1'b0;
      nextLevel_s   = level_r;
    end
    nextLimit_s = SPEEDCOUNTER_DATAWIDTH'(levelToLimit(64'(SPEEDCOUNTER_BASELIMIT), 32'(nextLevel_s)));
  end

  // Load-sequence and run FSM with all comparator-facing outputs registered.
  always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or negedge CC_SPEEDCOUNTER_RESET_InLow) begin
    if (!CC_SPEEDCOUNTER_RESET_InLow) begin
      state_r <= INIT;
      count_r <= '0;
      limit_r <= SPEEDCOUNTER_BASELIMIT;
      loadN_r <= 1'b1;
      tick_r  <= 1'b0;
      level_r <= '0;
    end else begin
      tick_r <= 1'b0;
      case (state_r)
        INIT: begin
          loadN_r <= 1'b1;
          state_r <= LD_SETUP;
        end
        LD_SETUP: begin
          loadN_r <= 1'b0;
          state_r <= LD_STROBE;
        end
        LD_STROBE: begin
          loadN_r <= 1'b1;
          count_r <= '0;
          state_r <= LD_RELEASE;
        end
        LD_RELEASE: begin
          loadN_r <= 1'b1;
          count_r <= '0;
          state_r <= RUN;
        end
        RUN: begin
          if (levelChange_s) begin
            level_r <= nextLevel_s;
            limit_r <= nextLimit_s;
            state_r <= LD_SETUP;
          end
          if (CC_SPEEDCOUNTER_enable_InHigh) begin
            if (!CC_SPEEDCOUNTER_compare_InLow) begin
              count_r <= '0;
              tick_r  <= 1'b1;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
            end else if (count_r > limit_r) begin
              // Comparator missed the limit: restart the period and reload it.
              count_r <= '0;
              tick_r  <= 1'b1;
              state_r <= LD_SETUP;
`endif
            end else begin
              count_r <= count_r + SPEEDCOUNTER_DATAWIDTH'(1);
            end
          end
        end
        default: begin
          loadN_r <= 1'b1;
          state_r <= INIT;
        end
      endcase
    end
  end

  assign CC_SPEEDCOUNTER_data_OutBUS       = count_r;
  assign CC_SPEEDCOUNTER_limit_OutBUS      = limit_r;
  assign CC_SPEEDCOUNTER_loadSignal_OutLow = loadN_r;
  assign CC_SPEEDCOUNTER_tick_OutHigh      = tick_r;
  assign CC_SPEEDCOUNTER_level_OutBUS      = level_r;

endmodule

// File: tb/tb_cc_speedcounter.sv
// Self-checking bench for cc_speedcounter with a behavioural comparator and reference model.
`timescale 1ns/1ps
module tb_cc_speedcounter;

  localparam int DW = 28;
  localparam int LEVELS = 4;
  localparam logic [DW-1:0] BASE = 28'd8;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  logic enable;
  logic upN;
  logic downN;
  logic compareN;
  logic [DW-1:0] dataBus;
  logic [DW-1:0] limitBus;
  logic loadN;
  logic tick;
  logic [1:0] level;

  always #5 clk = ~clk;

  cc_speedcounter #(
    .SPEEDCOUNTER_DATAWIDTH (DW),
    .SPEEDCOUNTER_LEVELS    (LEVELS),
    .SPEEDCOUNTER_BASELIMIT (BASE)
  ) dut (
    .CC_SPEEDCOUNTER_CLOCK_50        (clk),
    .CC_SPEEDCOUNTER_RESET_InLow     (rstN),
    .CC_SPEEDCOUNTER_enable_InHigh   (enable),
    .CC_SPEEDCOUNTER_speedUp_InLow   (upN),
    .CC_SPEEDCOUNTER_speedDown_InLow (downN),
    .CC_SPEEDCOUNTER_compare_InLow   (compareN),
    .CC_SPEEDCOUNTER_data_OutBUS     (dataBus),
    .CC_SPEEDCOUNTER_limit_OutBUS    (limitBus),
    .CC_SPEEDCOUNTER_loadSignal_OutLow (loadN),
    .CC_SPEEDCOUNTER_tick_OutHigh    (tick),
    .CC_SPEEDCOUNTER_level_OutBUS    (level)
  );

  // Comparator: captures the limit on the strobe's falling edge; staleOn fakes a wrong capture.
  logic [DW-1:0] cmpLimit = '1;
  logic staleOn = 1'b0;
  always @(negedge loadN) cmpLimit <= limitBus;
  assign compareN = !(dataBus >= (staleOn ? 28'd15 : cmpLimit));

  int errors = 0;
  int checks = 0;
  int strobeCnt = 0;

  // Reference model: remaining load-sequence cycles, counter, level and button history.
  int mRem;
  int mLevel;
  logic [DW-1:0] mCount;
  logic [DW-1:0] mLimit;
  bit mTick;
  bit [2:0] upHist;
  bit [2:0] dnHist;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRem   = 4;
    mLevel = 0;
    mCount = '0;
    mLimit = BASE;
    mTick  = 1'b0;
    upHist = 3'b111;
    dnHist = 3'b111;
  endtask

  // One clock edge: a button press is acted on when it was high 3 edges ago and low 2 edges ago.
  task automatic modelEdge();
    bit upReq;
    bit dnReq;
    int newLevel;
    logic [DW-1:0] oldLimit;
    upReq = upHist[2] && !upHist[1];
    dnReq = dnHist[2] && !dnHist[1];
    upHist = {upHist[1:0], upN};
    dnHist = {dnHist[1:0], downN};
    mTick = 1'b0;
    oldLimit = mLimit;
    if (mRem > 0) begin
      mRem--;
      if (mRem == 1) mCount = '0;
    end else begin
      newLevel = mLevel;
      if (upReq && !dnReq) newLevel = (mLevel >= LEVELS - 1) ? LEVELS - 1 : mLevel + 1;
      else if (dnReq && !upReq) newLevel = (mLevel == 0) ? 0 : mLevel - 1;
      if (newLevel != mLevel) begin
        mLevel = newLevel;
        mLimit = BASE >> newLevel;
        mRem   = 3;
      end
      if (enable) begin
        if (!compareN) begin
          mCount = '0;
          mTick  = 1'b1;
        end else if (WD && (mCount > oldLimit)) begin
          mCount = '0;
          mTick  = 1'b1;
          mRem   = 3;
        end else begin
          mCount = mCount + 28'd1;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    modelEdge();
    @(posedge clk);
    #1;
    if (loadN === 1'b0) strobeCnt++;
    check("count", dataBus, mCount);
    check("limit", limitBus, mLimit);
    check("loadSignal", loadN, (mRem == 2) ? 1'b0 : 1'b1);
    check("tick", tick, mTick);
    check("level", level, mLevel);
  endtask

  task automatic measurePeriod(output int p);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 100) begin step(); n++; end
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 100);
    p = n;
  endtask

  task automatic waitCount(input logic [DW-1:0] target);
    int n;
    n = 0;
    while (dataBus !== target && n < 60) begin step(); n++; end
    check("reach_count", dataBus, target);
  endtask

  task automatic press(input bit u, input bit d);
    if (u) upN = 1'b0;
    if (d) downN = 1'b0;
    repeat (4) step();
    upN = 1'b1;
    downN = 1'b1;
    repeat (6) step();
  endtask

  typedef struct {
    bit en;
    bit load;
    int count;
    bit tk;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int s0;
    int n;
    int tickSeen;

    vecs[0]  = '{1'b1, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 3, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 6, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 7, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1, 1'b0};

    rstN = 1'b0; enable = 1'b1; upN = 1'b1; downN = 1'b1;
    modelReset();
    #12;
    check("rst_count", dataBus, 0);
    check("rst_limit", limitBus, 8);
    check("rst_load", loadN, 1);
    check("rst_tick", tick, 0);
    check("rst_level", level, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Reset-release load sequence and first period.
    for (int i = 0; i < 14; i++) begin
      enable = vecs[i].en;
      step();
      check("vec_load", loadN, vecs[i].load);
      check("vec_count", dataBus, vecs[i].count);
      check("vec_tick", tick, vecs[i].tk);
    end
    check("cmp_loaded", cmpLimit, 8);
    measurePeriod(p);
    check("period_l0", p, 9);

    // speedUp at count 4.
    waitCount(28'd4);
    upN = 1'b0;
    repeat (3) step();
    check("up_level", level, 1);
    check("up_limit", limitBus, 4);
    step();
    check("up_strobe", loadN, 0);
    step();
    check("up_restart", dataBus, 0);
    upN = 1'b1;
    measurePeriod(p);
    check("period_l1", p, 5);

    // Two more presses reach level 3; a fourth saturates.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("l3_level", level, 3);
    check("l3_limit", limitBus, 1);
    measurePeriod(p);
    check("period_l3", p, 2);
    s0 = strobeCnt;
    press(1'b1, 1'b0);
    check("sat_strobes", strobeCnt - s0, 0);
    check("sat_level", level, 3);

    // Simultaneous up and down are both dropped.
    s0 = strobeCnt;
    press(1'b1, 1'b1);
    check("both_strobes", strobeCnt - s0, 0);
    check("both_level", level, 3);

    // A second down press landing in LD_STROBE is dropped.
    s0 = strobeCnt;
    downN = 1'b0; step();
    downN = 1'b1; step();
    downN = 1'b0; step();
    check("dn_level", level, 2);
    step();
    check("dn_strobe", loadN, 0);
    repeat (4) step();
    downN = 1'b1;
    repeat (6) step();
    check("drop_level", level, 2);
    check("drop_strobes", strobeCnt - s0, 1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("back_level", level, 0);

    // Enable low at count 5 freezes the count.
    waitCount(28'd5);
    enable = 1'b0;
    tickSeen = 0;
    repeat (10) begin step(); if (tick === 1'b1) tickSeen++; end
    check("hold_count", dataBus, 5);
    check("hold_notick", tickSeen, 0);
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (tick !== 1'b1 && n < 20);
    check("resume_tick", n, 4);

    // Stale comparator limit.
    waitCount(28'd2);
    staleOn = 1'b1;
`ifdef CC_SPEEDCOUNTER_WATCHDOG_EN
    waitCount(28'd9);
    step();
    check("wd_clear", dataBus, 0);
    check("wd_tick", tick, 1);
    n = 0;
    while (loadN !== 1'b0 && n < 6) begin step(); n++; end
    check("wd_reload", loadN, 0);
    staleOn = 1'b0;
    step();
    check("wd_cmp", cmpLimit, 8);
`else
    tickSeen = 0;
    n = 0;
    while (dataBus !== 28'd10 && n < 30) begin step(); n++; if (tick === 1'b1) tickSeen++; end
    check("stale_count", dataBus, 10);
    check("stale_notick", tickSeen, 0);
    staleOn = 1'b0;
    step();
    check("stale_recover", tick, 1);
`endif
    repeat (12) step();

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 14) == 0) upN = ~upN;
      if ($urandom_range(0, 14) == 0) downN = ~downN;
      step();
    end
    upN = 1'b1; downN = 1'b1; enable = 1'b1;
    repeat (8) step();

    // Reset during LD_STROBE releases the strobe immediately.
    upN = 1'b0;
    if (level == 2'd3) downN = 1'b0;
    n = 0;
    while (loadN !== 1'b0 && n < 10) begin step(); n++; end
    check("pre_rst_strobe", loadN, 0);
    #2 rstN = 1'b0;
    #1;
    check("async_load", loadN, 1);
    check("async_level", level, 0);
    check("async_limit", limitBus, 8);
    check("async_count", dataBus, 0);
    upN = 1'b1; downN = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
